// File: rtl/bsg_link_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : bsg_link_prbs_checker
// Description : Receive-side link training checker. Compares delayed data
//               lanes against a self-synchronizing PRBS-15 (x^15+x^14+1)
//               stream and reports lock, sticky per-lane error flags and
//               saturating error/word counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_link_prbs_checker #(
  parameter int width_p      = 16,
  parameter int lock_words_p = 32,
  parameter int cnt_width_p  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   locked_o,
  output logic [width_p-1:0]     lane_err_o,
  output logic [cnt_width_p-1:0] err_cnt_o,
  output logic [cnt_width_p-1:0] word_cnt_o
);

  localparam int RUN_W = $clog2(lock_words_p + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(lock_words_p - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SYNC  = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  // The recurrence reaches back at most 15 bits, so only the top 15 bits of
  // the previous word are ever needed to predict the current one.
  logic [14:0]            prev_q, prev_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [width_p-1:0]     lane_err_q, lane_err_d;
  logic [cnt_width_p-1:0] err_cnt_q, err_cnt_d;
  logic [cnt_width_p-1:0] word_cnt_q, word_cnt_d;

  // Received serial history: prev-word tail followed by the low current bits.
  // Bit k of the current word sits at index k+15; its taps are k and k+1.
  logic [width_p:0]       w_hist;
  logic [width_p-1:0]     w_exp;
  logic [width_p-1:0]     w_mismatch;
  logic                   w_word_err;

  assign w_hist     = {data_i[width_p-15:0], prev_q};
  assign w_exp      = w_hist[width_p-1:0] ^ w_hist[width_p:1];
  assign w_mismatch = data_i ^ w_exp;
  assign w_word_err = |w_mismatch;

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      lane_err_q <= '0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      lane_err_q <= lane_err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state logic: priming, run-length lock search and locked accumulation.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    lane_err_d = lane_err_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;

    if (!en_i) begin
      // Disable drops lock immediately; accumulated results are kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          if (valid_i) begin
            prev_d  = data_i[width_p-1:width_p-15];
            run_d   = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (valid_i) begin
            prev_d = data_i[width_p-1:width_p-15];
            if (w_word_err) begin
              run_d = '0;
            end else if (run_q == RUN_LAST) begin
              state_d = ST_LOCK;
            end else begin
              run_d = run_q + 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (valid_i) begin
            prev_d = data_i[width_p-1:width_p-15];
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            if (w_word_err) begin
              lane_err_d = lane_err_q | w_mismatch;
              if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Clear overrides any accumulation in the same cycle.
    if (clear_i) begin
      lane_err_d = '0;
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  assign locked_o   = (state_q == ST_LOCK);
  assign lane_err_o = lane_err_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

endmodule
`default_nettype wire

// File: doc/bsg_link_prbs_checker.md
Name: bsg_link_prbs_checker

Overview:
- Receive-side training checker placed directly downstream of the per-bit programmable link delay line.
- Consumes the delayed valid/data lanes and checks them against a self-synchronizing PRBS-15 stream.
- Reports lock, sticky per-lane error flags and saturating counters.
- Software sweeps the delay-tap settings per lane and reads these results to centre each lane's sampling point.

Parameters:
- width_p, 16, data lanes checked; must be >= 15.
- lock_words_p, 32, consecutive error-free valid words required to declare lock; >= 1.
- cnt_width_p, 16, width of the error and word counters.

Ports:
- clk_i  input  1  link receive clock; all state is in this domain.
- reset_i  input  1  asynchronous, active-high reset.
- en_i  input  1  enables checking; low forces IDLE.
- clear_i  input  1  synchronous clear of lane_err_o, err_cnt_o and word_cnt_o; lock state is unaffected.
- valid_i  input  1  delayed valid lane; data_i is meaningful only when high.
- data_i  input  width_p  delayed data lanes.
- locked_o  output  1  high in LOCK state.
- lane_err_o  output  width_p  sticky per-lane mismatch flags, collected in LOCK only.
- err_cnt_o  output  cnt_width_p  number of erroneous words in LOCK; saturates at all-ones.
- word_cnt_o  output  cnt_width_p  number of valid words checked in LOCK; saturates at all-ones.

Behaviour:
- Reset: state=IDLE; locked_o=0; lane_err_o=0; err_cnt_o=0; word_cnt_o=0; prev-word register=0; run counter=0.
- Serial stream definition: word n bit k is stream bit j=width_p*n+k (bit 0 first). Pattern rule: b[j]=b[j-14]^b[j-15] (x^15+x^14+1).
- Expected bits: for each bit k, exp[k] is formed from the received bits 14 and 15 positions earlier. These come from the concatenation {data_i, prev}, using current-word bits for k>=15 and prev-word bits otherwise.
- mismatch[k] = data_i[k]^exp[k]. Word error = |mismatch. The check is combinational and registered into state the same cycle.
- A single flipped bit at position k flags up to three positions: k itself, k+14 and k+15 (those >= width_p fall into the next word at k+14-width_p and k+15-width_p).
- Cycles with valid_i=0 are ignored entirely; prev and counters hold.
- Every valid word loads prev<=data_i, in all states except IDLE.

FSM:
- IDLE: locked_o=0. When en_i=1, go to PRIME.
- PRIME: the first valid word loads prev only, with no check. Then go to SYNC with run counter=0.
- SYNC:
  - Each valid word: on word error, run counter<=0; otherwise run counter+1.
  - When the run counter reaches lock_words_p on a clean word, go to LOCK on the next edge.
  - Words checked in SYNC do not touch lane_err_o or the counters.
- LOCK: locked_o=1. Each valid word:
  - word_cnt_o+=1 (saturating).
  - On word error: err_cnt_o+=1 (saturating) and lane_err_o|=mismatch.
  - LOCK is held regardless of the error rate; lock is only lost via en_i or reset.
- en_i low in any state: IDLE on the next edge; locked_o drops that edge; lane_err_o and the counters hold their values.
- clear_i:
  - When asserted together with an update, the clear wins for that cycle: the word is not accumulated.
  - The run counter and state are unaffected.
- Saturation: at all-ones, a counter holds; there is no wrap.
- Latency: outputs reflect a valid word on the edge after it is presented.
- Asynchronous reset mid-operation returns all registers to their reset values immediately.

Test Plan:
- Reset, en_i=1, continuous clean PRBS-15 from seed 0x7FFF, valid every cycle -> locked_o rises on the edge after word 1+32 (word 0 primes); lane_err_o=0; err_cnt_o=0; word_cnt_o increments each cycle after lock.
- Locked, flip bit 3 of one word -> lane_err_o=0x000E (bit 3 in that word; bits 1 and 2 in the following word); err_cnt_o=2; locked_o stays 1.
- In SYNC, inject one error at clean-run count 20 -> run counter resets; lock asserts only after 32 further clean words.
- Clean stream with valid_i toggling 1/0 -> bubbles ignored; lock after 33 valid words; no errors; word_cnt_o counts valid words only.
- err_cnt_o preloaded via continuous random data with cnt_width_p=4 -> err_cnt_o saturates at 0xF; clear_i pulse -> 0 next edge with locked_o unchanged; en_i low -> locked_o=0 next edge.
- Assert reset_i asynchronously mid-LOCK between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
